cmac_accumulator: RTL and testbench
===================================

Name: cmac_accumulator

Overview:
- Sequential complex accumulator directly downstream of the combinational ccmult complex multiplier in the QFT datapath.
- Accepts a stream of S3.4 complex products (pr, pi) and sums N_TERMS consecutive products, forming one matrix-row dot product, i.e. one output amplitude of the QFT matrix-vector product.
- Saturates each sum back to S3.4 and presents it on a valid/ready output port.
- Tags each output with its row index and a last-row flag.

Parameters:
TOTAL_WIDTH, 8, total fixed-point word width (S3.4; matches `TOTAL_WIDTH in fixed_point_params.vh)
FRAC_WIDTH, 4, fractional bits; informational only, no rescaling is performed here
N_TERMS, 4, products summed per output amplitude (= matrix dimension, 2^qubits); must be ≥2
GUARD_BITS, 3, extra accumulator MSBs; must satisfy 2^GUARD_BITS ≥ N_TERMS

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
flush  in  1  synchronous abort: discard partial sum, return to ACCUM with counters zeroed
in_valid  in  1  product present on in_pr/in_pi
in_ready  out  1  accumulator can accept a product this cycle
in_pr  in  TOTAL_WIDTH  signed real part of product (ccmult pr)
in_pi  in  TOTAL_WIDTH  signed imaginary part of product (ccmult pi)
out_valid  out  1  completed amplitude available
out_ready  in  1  consumer accepts amplitude
out_re  out  TOTAL_WIDTH  saturated real sum, S3.4
out_im  out  TOTAL_WIDTH  saturated imaginary sum, S3.4
out_row  out  clog2(N_TERMS)  row index of the presented amplitude
out_last  out  1  high with out_valid when out_row == N_TERMS-1
sat_flag  out  1  high with out_valid if either component saturated

Behaviour:
- Single clock domain. rst and flush are sampled on the rising edge of clk.
- States: ACCUM, OUT.
- Reset (rst=1):
  - state=ACCUM; both accumulators=0; term_cnt=0; row_cnt=0.
  - out_valid=0, out_re=0, out_im=0, out_row=0, out_last=0, sat_flag=0.
  - in_ready=1 from the first cycle after reset.
  - rst overrides flush and every handshake.
- Accumulator width: TOTAL_WIDTH+GUARD_BITS bits, signed. Inputs are sign-extended before addition. No overflow is possible inside the accumulator.
- ACCUM state:
  - in_ready=1 and out_valid=0.
  - A transfer occurs when in_valid && in_ready.
  - On each transfer, the product is added to the accumulators and term_cnt increments.
  - On the transfer where term_cnt == N_TERMS-1, the final sum (including that product) is saturated and registered on out_re/out_im/sat_flag. In the same cycle, term_cnt→0, accumulators→0, and state→OUT.
  - Latency: out_valid rises on the cycle after the last term is accepted.
- Saturation:
  - Sums above 2^(TOTAL_WIDTH-1)-1 clamp to 127.
  - Sums below -2^(TOTAL_WIDTH-1) clamp to -128.
  - Each component clamps independently.
  - sat_flag = OR of the two component clamps.
- OUT state:
  - in_ready=0, out_valid=1. Outputs stay stable while out_ready=0.
  - When out_ready=1, the amplitude is consumed and state→ACCUM.
  - On that transfer, row_cnt increments, wrapping from N_TERMS-1 to 0.
  - out_row and out_last reflect row_cnt while out_valid is high.
  - The earliest next input accept is the cycle after the output handshake. There is no overlap; throughput is N_TERMS+1 cycles per amplitude when neither side stalls.
- flush=1 (rst=0):
  - Next state is ACCUM; accumulators, term_cnt and row_cnt→0; out_valid→0.
  - Any pending OUT amplitude is dropped. A simultaneous input transfer is ignored (flush wins).
  - out_re/out_im may retain stale values but must not be qualified by out_valid.
- in_valid while in_ready=0: the product is not consumed; the upstream block must hold it.
- Mid-operation rst or flush: the partial sum never appears on the output.

Test Plan:
- Basic sum: after reset, feed (16,0),(16,0),(-8,4),(0,-4) back-to-back with out_ready=1 → one cycle after the 4th accept: out_valid=1, out_re=24, out_im=0, out_row=0, sat_flag=0.
- Positive saturation: four terms of (40,44) (ccmult output for (24+16i)*(32+8i)) → out_re=127, out_im=127, sat_flag=1.
- Negative/mixed saturation: four terms of (-64,10) → out_re=-128, out_im=40, sat_flag=1.
- Backpressure: complete a sum with out_ready=0 for 3 cycles → out_valid and data held constant, in_ready=0 throughout; raise out_ready → out_valid drops next cycle, in_ready=1.
- Row wrap: stream 4 full rows with out_ready=1 → out_row sequence 0,1,2,3 with out_last=1 only on row 3; 5th row reports out_row=0.
- Abort: feed 2 terms of (50,50), pulse flush (also pulse rst in a second run), then feed (1,2),(1,2),(1,2),(1,2) → out_re=4, out_im=8, out_row=0, with no earlier out_valid pulse.

Source files
------------

// File: rtl/cmac_accumulator.sv
// rtl/cmac_accumulator.sv - sums N_TERMS complex S3.4 products into one saturated QFT amplitude
// Two-state ACCUM/OUT machine; products are accepted only in ACCUM, results are held in OUT.
module cmac_accumulator #(
  parameter int TOTAL_WIDTH = 8,
  parameter int FRAC_WIDTH  = 4,
  parameter int N_TERMS     = 4,
  parameter int GUARD_BITS  = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [TOTAL_WIDTH-1:0]     in_pr,
  input  logic [TOTAL_WIDTH-1:0]     in_pi,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [TOTAL_WIDTH-1:0]     out_re,
  output logic [TOTAL_WIDTH-1:0]     out_im,
  output logic [$clog2(N_TERMS)-1:0] out_row,
  output logic                       out_last,
  output logic                       sat_flag
);

  localparam int AW = TOTAL_WIDTH + GUARD_BITS;
  localparam int RW = $clog2(N_TERMS);
  localparam logic [RW-1:0] LAST = RW'(N_TERMS - 1);
  localparam logic signed [AW-1:0] SMAX = AW'((2 ** (TOTAL_WIDTH - 1)) - 1);
  localparam logic signed [AW-1:0] SMIN = ~SMAX;

  typedef enum logic {ACCUM, OUT} state_t;

  state_t                 state;
  logic signed [AW-1:0]   acc_re, acc_im;
  logic signed [AW-1:0]   sum_re, sum_im;
  logic [RW-1:0]          term_cnt, row_cnt;
  logic [TOTAL_WIDTH:0]   sat_re, sat_im;
  logic                   accept;

  // Operands stay in S3.4 throughout; the fraction width only documents the format.
  logic frac_unused;
  assign frac_unused = (FRAC_WIDTH > 0);

  function automatic logic [TOTAL_WIDTH:0] saturate(input logic signed [AW-1:0] v);
    if (v > SMAX)      return {1'b1, SMAX[TOTAL_WIDTH-1:0]};
    else if (v < SMIN) return {1'b1, SMIN[TOTAL_WIDTH-1:0]};
    else               return {1'b0, v[TOTAL_WIDTH-1:0]};
  endfunction

  always_comb begin
    sum_re = acc_re + $signed({{GUARD_BITS{in_pr[TOTAL_WIDTH-1]}}, in_pr});
    sum_im = acc_im + $signed({{GUARD_BITS{in_pi[TOTAL_WIDTH-1]}}, in_pi});
    sat_re = saturate(sum_re);
    sat_im = saturate(sum_im);
  end

  assign accept   = in_valid && in_ready;
  assign out_row  = row_cnt;
  assign out_last = out_valid && (row_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCUM;
      acc_re    <= '0;
      acc_im    <= '0;
      term_cnt  <= '0;
      row_cnt   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      sat_flag  <= 1'b0;
    end else if (flush) begin
      // out_re/out_im keep stale data; out_valid low makes it meaningless.
      state     <= ACCUM;
      acc_re    <= '0;
      acc_im    <= '0;
      term_cnt  <= '0;
      row_cnt   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            if (term_cnt == LAST) begin
              out_re    <= sat_re[TOTAL_WIDTH-1:0];
              out_im    <= sat_im[TOTAL_WIDTH-1:0];
              sat_flag  <= sat_re[TOTAL_WIDTH] | sat_im[TOTAL_WIDTH];
              acc_re    <= '0;
              acc_im    <= '0;
              term_cnt  <= '0;
              out_valid <= 1'b1;
              in_ready  <= 1'b0;
              state     <= OUT;
            end else begin
              acc_re   <= sum_re;
              acc_im   <= sum_im;
              term_cnt <= term_cnt + 1'b1;
            end
          end
        end
        OUT: begin
          if (out_ready) begin
            row_cnt   <= (row_cnt == LAST) ? '0 : row_cnt + 1'b1;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_cmac_accumulator.sv
// tb/tb_cmac_accumulator.sv - table vectors, abort sequences and random rows against an arithmetic model
// Inputs are driven and outputs sampled on the falling edge.
module tb_cmac_accumulator;

  logic       clk = 1'b0;
  logic       rst, flush, in_valid, in_ready, out_valid, out_ready, out_last, sat_flag;
  logic [7:0] in_pr, in_pi, out_re, out_im;
  logic [1:0] out_row;

  int total = 0;
  int passed = 0;
  int exp_row = 0;

  cmac_accumulator #(.TOTAL_WIDTH(8), .FRAC_WIDTH(4), .N_TERMS(4), .GUARD_BITS(3)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pr(in_pr), .in_pi(in_pi),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
    .out_row(out_row), .out_last(out_last), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0][7:0] pr;
    logic [3:0][7:0] pi;
    int re, im, sat, stall;
  } vec_t;

  vec_t tbl [5];

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  function automatic int clamp(input int s);
    if (s > 127) return 127;
    if (s < -128) return -128;
    return s;
  endfunction

  task automatic send(input logic [7:0] pr, input logic [7:0] pi, input int gap);
    int n;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_pr = pr;
    in_pi = pi;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("send_timeout", 1, 0);
    check("valid_low_while_accumulating", int'(out_valid), 0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_row(input logic [3:0][7:0] pr, input logic [3:0][7:0] pi,
                         input int er, input int ei, input int es, input int stall,
                         input int gap, input string tag);
    logic [7:0] hr, hi;
    out_ready = (stall == 0);
    for (int k = 0; k < 4; k++) send(pr[k], pi[k], gap);
    check({tag, "_valid"}, int'(out_valid), 1);
    check({tag, "_re"}, int'($signed(out_re)), er);
    check({tag, "_im"}, int'($signed(out_im)), ei);
    check({tag, "_sat"}, int'(sat_flag), es);
    check({tag, "_row"}, int'(out_row), exp_row);
    check({tag, "_last"}, int'(out_last), int'(exp_row == 3));
    hr = out_re;
    hi = out_im;
    for (int c = 0; c < stall; c++) begin
      in_valid = 1'b1;
      in_pr = 8'h55;
      in_pi = 8'h33;
      @(negedge clk);
      check({tag, "_hold_valid"}, int'(out_valid), 1);
      check({tag, "_hold_ready"}, int'(in_ready), 0);
      check({tag, "_hold_data"}, int'({out_re, out_im}), int'({hr, hi}));
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_drain_valid"}, int'(out_valid), 0);
    check({tag, "_drain_ready"}, int'(in_ready), 1);
    exp_row = (exp_row + 1) % 4;
  endtask

  task automatic abort_run(input bit use_rst);
    out_ready = 1'b1;
    send(8'd50, 8'd50, 0);
    send(8'd50, 8'd50, 0);
    in_valid = 1'b1;
    in_pr = 8'd50;
    in_pi = 8'd50;
    if (use_rst) rst = 1'b1;
    else flush = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    check("abort_valid", int'(out_valid), 0);
    check("abort_ready", int'(in_ready), 1);
    if (use_rst) check("abort_rst_re", int'(out_re), 0);
    exp_row = 0;
    run_row({4{8'd1}}, {4{8'd2}}, 4, 8, 0, 0, 0, use_rst ? "after_rst" : "after_flush");
  endtask

  initial begin
    logic [3:0][7:0] rpr, rpi;
    int sr, si, er, ei;

    tbl[0] = '{pr: {8'h00, 8'hF8, 8'h10, 8'h10}, pi: {8'hFC, 8'h04, 8'h00, 8'h00}, re: 24,   im: 0,    sat: 0, stall: 0};
    tbl[1] = '{pr: {4{8'h28}},                  pi: {4{8'h2C}},                  re: 127,  im: 127,  sat: 1, stall: 3};
    tbl[2] = '{pr: {4{8'hC0}},                  pi: {4{8'h0A}},                  re: -128, im: 40,   sat: 1, stall: 0};
    tbl[3] = '{pr: {8'h1F, 8'h20, 8'h20, 8'h20}, pi: {4{8'hE0}},                  re: 127,  im: -128, sat: 0, stall: 1};
    tbl[4] = '{pr: {4{8'h20}},                  pi: {8'hDF, 8'hE0, 8'hE0, 8'hE0}, re: 127,  im: -128, sat: 1, stall: 0};

    rst = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    in_pr = '0;
    in_pi = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_re", int'(out_re), 0);
    check("rst_out_im", int'(out_im), 0);
    check("rst_out_row", int'(out_row), 0);
    check("rst_out_last", int'(out_last), 0);
    check("rst_sat_flag", int'(sat_flag), 0);
    check("rst_in_ready", int'(in_ready), 1);

    for (int i = 0; i < 5; i++)
      run_row(tbl[i].pr, tbl[i].pi, tbl[i].re, tbl[i].im, tbl[i].sat, tbl[i].stall, 0,
              $sformatf("vec%0d", i));

    abort_run(1'b0);
    abort_run(1'b1);

    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) send(8'd1, 8'd1, 0);
    check("out_flush_pending", int'(out_valid), 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("out_flush_valid", int'(out_valid), 0);
    check("out_flush_ready", int'(in_ready), 1);
    exp_row = 0;

    for (int r = 0; r < 20; r++) begin
      sr = 0;
      si = 0;
      for (int k = 0; k < 4; k++) begin
        rpr[k] = 8'($urandom);
        rpi[k] = 8'($urandom);
        sr += int'($signed(rpr[k]));
        si += int'($signed(rpi[k]));
      end
      er = clamp(sr);
      ei = clamp(si);
      run_row(rpr, rpi, er, ei, int'((er != sr) || (ei != si)),
              int'($urandom_range(0, 2)), int'($urandom_range(0, 1)), $sformatf("rnd%0d", r));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
